// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile driver and the array top:
// FSM states, CSR map, default geometry and instruction word layout.
package systolic_pkg;

  localparam int MAX_DIM = 32;
  localparam int VEC_W   = 256;

  // Instruction word: {8'b0, n_rows[11:0], n_cols[11:0]}; CFG uses the same layout.
  localparam int DIM_W          = 12;
  localparam int INSTR_COLS_LSB = 0;
  localparam int INSTR_ROWS_LSB = 12;

  localparam logic [7:0] CSR_CTRL      = 8'h00;
  localparam logic [7:0] CSR_CFG       = 8'h01;
  localparam logic [7:0] CSR_STATUS    = 8'h02;
  localparam logic [7:0] CSR_RES_COUNT = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_STREAM,
    S_COLLECT,
    S_DONE
  } state_e;

  function automatic logic [DIM_W-1:0] dim_min(input logic [DIM_W-1:0] a,
                                               input logic [DIM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_tile_driver_if.sv
// Bus bundle of the tile driver: CSR port, operand load port, instruction and
// operand streams, result stream and result read port.
// master = the tile driver, slave = whatever surrounds it.
interface systolic_tile_driver_if #(
  parameter int VEC_W = systolic_pkg::VEC_W
) ();
  logic [7:0]       csr_address;
  logic             csr_write;
  logic [31:0]      csr_writedata;
  logic             csr_read;
  logic [31:0]      csr_readdata;

  logic             ld_valid;
  logic             ld_sel;
  logic [4:0]       ld_addr;
  logic [VEC_W-1:0] ld_data;

  logic [31:0]      st_instr_data;
  logic             st_instr_valid;
  logic             st_instr_ready;

  logic [VEC_W-1:0] st_rows_data;
  logic             st_rows_valid;
  logic             st_rows_ready;
  logic [VEC_W-1:0] st_cols_data;
  logic             st_cols_valid;
  logic             st_cols_ready;

  logic [VEC_W-1:0] res_data;
  logic             res_valid;
  logic             res_ready;

  logic [4:0]       rd_addr;
  logic [VEC_W-1:0] rd_data;

  modport master (
    input  csr_address, csr_write, csr_writedata, csr_read,
    output csr_readdata,
    input  ld_valid, ld_sel, ld_addr, ld_data,
    output st_instr_data, st_instr_valid,
    input  st_instr_ready,
    output st_rows_data, st_rows_valid, st_cols_data, st_cols_valid,
    input  st_rows_ready, st_cols_ready,
    input  res_data, res_valid,
    output res_ready,
    input  rd_addr,
    output rd_data
  );

  modport slave (
    output csr_address, csr_write, csr_writedata, csr_read,
    input  csr_readdata,
    output ld_valid, ld_sel, ld_addr, ld_data,
    input  st_instr_data, st_instr_valid,
    output st_instr_ready,
    input  st_rows_data, st_rows_valid, st_cols_data, st_cols_valid,
    output st_rows_ready, st_cols_ready,
    output res_data, res_valid,
    input  res_ready,
    output rd_addr,
    input  rd_data
  );
endinterface

// File: rtl/vector_buffer.sv
// DEPTH x W vector store: one write port, one read port with a registered
// output. Storage is not reset; only the read register is.
module vector_buffer #(
  parameter int DEPTH = 32,
  parameter int W     = 256,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  // Storage write.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read, cleared by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_rdata <= '0;
    else       o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/systolic_tile_driver.sv
// Tile driver: issues one instruction, streams min(n_rows, n_cols) row/col
// operand pairs in lockstep, then collects n_cols result vectors.
module systolic_tile_driver #(
  parameter int MAX_DIM = systolic_pkg::MAX_DIM,
  parameter int VEC_W   = systolic_pkg::VEC_W
) (
  input  logic                   clock_sink,
  input  logic                   reset_sink_reset,
  systolic_tile_driver_if.master bus
);
  import systolic_pkg::*;

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_cfg;
  logic             r_cfg_err;
  logic [DIM_W-1:0] r_res_cnt;
  logic [4:0]       r_beat;
  logic [4:0]       w_rd_idx;
  logic [DIM_W-1:0] w_n_rows, w_n_cols, w_k;
  logic             w_busy, w_idle_like, w_start, w_cfg_ok, w_launch, w_reject;
  logic             w_beat_fire, w_beat_last, w_res_fire, w_res_last, w_ld_ok;
  logic [31:0]      w_csr_rdata;

  assign w_n_cols    = r_cfg[INSTR_COLS_LSB +: DIM_W];
  assign w_n_rows    = r_cfg[INSTR_ROWS_LSB +: DIM_W];
  assign w_k         = dim_min(w_n_rows, w_n_cols);
  assign w_busy      = (r_state == S_INSTR) || (r_state == S_STREAM) || (r_state == S_COLLECT);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start     = bus.csr_write && (bus.csr_address == CSR_CTRL) && bus.csr_writedata[0];
  assign w_cfg_ok    = (w_n_rows != '0) && (w_n_rows <= DIM_W'(MAX_DIM)) &&
                       (w_n_cols != '0) && (w_n_cols <= DIM_W'(MAX_DIM));
  assign w_launch    = w_start && w_idle_like && w_cfg_ok;
  assign w_reject    = w_start && w_idle_like && !w_cfg_ok;

  // Row and col must both be accepted in the same cycle; no partial advance.
  assign w_beat_fire = (r_state == S_STREAM) && bus.st_rows_ready && bus.st_cols_ready;
  assign w_beat_last = w_beat_fire && (DIM_W'(r_beat) == w_k - DIM_W'(1));
  assign w_res_fire  = (r_state == S_COLLECT) && bus.res_valid;
  assign w_res_last  = w_res_fire && (r_res_cnt + DIM_W'(1) == w_n_cols);
  assign w_ld_ok     = bus.ld_valid && w_idle_like && (int'(bus.ld_addr) < MAX_DIM);

  // The operand buffers have a registered read, so address the beat that will
  // be on the bus next cycle: index 0 while waiting in INSTR, then k or k+1.
  assign w_rd_idx = (r_state == S_STREAM) ? (w_beat_fire ? r_beat + 5'd1 : r_beat) : 5'd0;

  assign bus.st_instr_valid = (r_state == S_INSTR);
  assign bus.st_instr_data  = {8'h00, w_n_rows, w_n_cols};
  assign bus.st_rows_valid  = (r_state == S_STREAM);
  assign bus.st_cols_valid  = (r_state == S_STREAM);
  assign bus.res_ready      = (r_state == S_COLLECT);
  assign bus.csr_readdata   = w_csr_rdata;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_launch)           w_state_nxt = S_INSTR;
      S_INSTR:        if (bus.st_instr_ready) w_state_nxt = S_STREAM;
      S_STREAM:       if (w_beat_last)        w_state_nxt = S_COLLECT;
      S_COLLECT:      if (w_res_last)         w_state_nxt = S_DONE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_sink or posedge reset_sink_reset) begin
    if (reset_sink_reset) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // CFG, error flag, beat index and result counter.
  always_ff @(posedge clock_sink or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_cfg     <= '0;
      r_cfg_err <= 1'b0;
      r_res_cnt <= '0;
      r_beat    <= '0;
    end else begin
      if (bus.csr_write && (bus.csr_address == CSR_CFG) && !w_busy) r_cfg <= bus.csr_writedata;
      if (w_launch)      r_cfg_err <= 1'b0;
      else if (w_reject) r_cfg_err <= 1'b1;
      if (w_launch)        r_res_cnt <= '0;
      else if (w_res_fire) r_res_cnt <= r_res_cnt + DIM_W'(1);
      if (w_launch)         r_beat <= '0;
      else if (w_beat_fire) r_beat <= r_beat + 5'd1;
    end
  end

  // CSR read mux; write-only and unmapped addresses read as zero.
  always_comb begin
    w_csr_rdata = '0;
    if (bus.csr_read) begin
      case (bus.csr_address)
        CSR_CFG:       w_csr_rdata = r_cfg;
        CSR_STATUS:    w_csr_rdata = {29'd0, r_cfg_err, (r_state == S_DONE), w_busy};
        CSR_RES_COUNT: w_csr_rdata = {{(32-DIM_W){1'b0}}, r_res_cnt};
        default:       w_csr_rdata = '0;
      endcase
    end
  end

  vector_buffer #(.DEPTH(MAX_DIM), .W(VEC_W), .AW(5)) u_row_buf (
    .i_clk(clock_sink), .i_rst(reset_sink_reset),
    .i_we(w_ld_ok && !bus.ld_sel), .i_waddr(bus.ld_addr), .i_wdata(bus.ld_data),
    .i_raddr(w_rd_idx), .o_rdata(bus.st_rows_data)
  );

  vector_buffer #(.DEPTH(MAX_DIM), .W(VEC_W), .AW(5)) u_col_buf (
    .i_clk(clock_sink), .i_rst(reset_sink_reset),
    .i_we(w_ld_ok && bus.ld_sel), .i_waddr(bus.ld_addr), .i_wdata(bus.ld_data),
    .i_raddr(w_rd_idx), .o_rdata(bus.st_cols_data)
  );

  vector_buffer #(.DEPTH(MAX_DIM), .W(VEC_W), .AW(5)) u_res_buf (
    .i_clk(clock_sink), .i_rst(reset_sink_reset),
    .i_we(w_res_fire), .i_waddr(r_res_cnt[4:0]), .i_wdata(bus.res_data),
    .i_raddr(bus.rd_addr), .o_rdata(bus.rd_data)
  );
endmodule

// File: tb/tb_systolic_tile_driver.sv
// Directed bench for systolic_tile_driver: reset, config errors, full and
// rectangular tiles, backpressure, busy-time pokes, load+start, mid-run reset.
module tb_systolic_tile_driver;
  import systolic_pkg::*;

  localparam int VW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_tile_driver_if #(.VEC_W(VW)) bus ();

  systolic_tile_driver #(.MAX_DIM(32), .VEC_W(VW)) dut (
    .clock_sink(clk), .reset_sink_reset(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] mrow [32];
  logic [VW-1:0] mcol [32];
  logic [VW-1:0] cap_rows [$];
  logic [VW-1:0] cap_cols [$];

  int          o_instr_n, o_beats, o_vcyc, o_vmis, o_res;
  logic [31:0] o_instr_w;
  bit          o_tmo;

  function automatic logic [VW-1:0] pat(input logic [7:0] tag, input int i);
    logic [VW-1:0] v;
    for (int l = 0; l < VW/32; l++) v[l*32 +: 32] = {tag, 8'(i), 8'(l), 8'hA5 ^ 8'(i*7)};
    return v;
  endfunction

  function automatic int cap_bad();
    int b = 0;
    for (int k = 0; k < cap_rows.size(); k++)
      if (cap_rows[k] !== mrow[k] || cap_cols[k] !== mcol[k]) b++;
    return b;
  endfunction

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_address = a; bus.csr_write = 1'b1; bus.csr_writedata = d;
    @(negedge clk);
    bus.csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
    bus.csr_address = a; bus.csr_read = 1'b1;
    #1 d = bus.csr_readdata;
    bus.csr_read = 1'b0;
  endtask

  task automatic ld(input bit sel, input int a, input logic [VW-1:0] d);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_sel = sel; bus.ld_addr = 5'(a); bus.ld_data = d;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    if (sel) mcol[a] = d; else mrow[a] = d;
  endtask

  task automatic read_res(input int a, output logic [VW-1:0] d);
    @(negedge clk); bus.rd_addr = 5'(a);
    @(negedge clk); d = bus.rd_data;
  endtask

  // Issues start and acts as the array: records instruction, operand beats and
  // result handshakes until exp_res results plus a few idle cycles.
  task automatic run_tile(input int exp_res, input bit rnd, input bit pokes, input bit ld_with_start);
    bit p1 = 0, p2 = 0, p3 = 0;
    int extra = 0;
    o_instr_n = 0; o_beats = 0; o_vcyc = 0; o_vmis = 0; o_res = 0; o_instr_w = '0; o_tmo = 1;
    cap_rows.delete(); cap_cols.delete();
    @(negedge clk);
    bus.csr_address = CSR_CTRL; bus.csr_write = 1'b1; bus.csr_writedata = 32'h1;
    if (ld_with_start) begin
      bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 5'd0; bus.ld_data = pat(8'h44, 0);
      mrow[0] = pat(8'h44, 0);
    end
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      bus.csr_write = 1'b0; bus.ld_valid = 1'b0;
      bus.st_instr_ready = 1'b1; bus.st_rows_ready = 1'b1;
      bus.st_cols_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.res_valid = 1'b1; bus.res_data = pat(8'h33, o_res);
      if (pokes && o_beats == 1 && !p1) begin
        bus.csr_address = CSR_CTRL; bus.csr_write = 1'b1; bus.csr_writedata = 32'h1; p1 = 1;
      end else if (pokes && o_beats == 2 && !p2) begin
        bus.csr_address = CSR_CFG; bus.csr_write = 1'b1; bus.csr_writedata = 32'h1001; p2 = 1;
      end
      if (pokes && bus.res_ready && !p3) begin
        bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 5'd0; bus.ld_data = '1; p3 = 1;
      end
      #1;
      if (bus.st_instr_valid) begin o_instr_n++; o_instr_w = bus.st_instr_data; end
      if (bus.st_rows_valid !== bus.st_cols_valid) o_vmis++;
      if (bus.st_rows_valid) o_vcyc++;
      if (bus.st_rows_valid && bus.st_cols_ready) begin
        cap_rows.push_back(bus.st_rows_data); cap_cols.push_back(bus.st_cols_data); o_beats++;
      end
      if (bus.res_ready) o_res++;
      if (o_res >= exp_res) extra++;
      if (extra > 3) begin o_tmo = 0; break; end
      @(negedge clk);
    end
    bus.res_valid = 1'b0; bus.csr_write = 1'b0; bus.ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2;
    checks++; if ({bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid, bus.res_ready} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid, bus.res_ready}); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
    checks++; if (bus.csr_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", bus.csr_readdata); end
    csr_rd(CSR_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    csr_rd(CSR_CFG, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cfg got %h want 0", d); end
    csr_rd(CSR_RES_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_res_count got %h want 0", d); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    csr_rd(CSR_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_status got %h want 0", d); end
  endtask

  task automatic test_cfg_err();
    logic [31:0] d;
    logic [31:0] cfgs [2];
    bit seen;
    cfgs[0] = 32'h0000_0005;  // rows 0
    cfgs[1] = 32'h0000_1021;  // rows 1, cols 33
    for (int t = 0; t < 2; t++) begin
      seen = 0;
      bus.st_instr_ready = 1'b1;
      csr_wr(CSR_CFG, cfgs[t]);
      csr_wr(CSR_CTRL, 32'h1);
      for (int c = 0; c < 5; c++) begin
        if (bus.st_instr_valid !== 1'b0) seen = 1;
        @(negedge clk);
      end
      csr_rd(CSR_STATUS, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL cfg_err_status[%0d] got %h want 4", t, d); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cfg_err_instr[%0d] got %b want 0", t, seen); end
    end
    csr_rd(CSR_CFG, d);
    checks++; if (d !== 32'h1021) begin errors++; $display("FAIL cfg_readback got %h want 1021", d); end
  endtask

  task automatic test_full_tile();
    logic [31:0] d;
    logic [VW-1:0] v;
    int addrs [3];
    addrs[0] = 0; addrs[1] = 17; addrs[2] = 31;
    for (int i = 0; i < 32; i++) begin ld(1'b0, i, pat(8'h11, i)); ld(1'b1, i, pat(8'h22, i)); end
    csr_wr(CSR_CFG, 32'h0002_0020);
    run_tile(32, 1'b0, 1'b0, 1'b0);
    checks++; if (o_tmo !== 1'b0) begin errors++; $display("FAIL full_timeout got %b want 0", o_tmo); end
    checks++; if (o_instr_n !== 1) begin errors++; $display("FAIL full_instr_count got %0d want 1", o_instr_n); end
    checks++; if (o_instr_w !== 32'h0002_0020) begin errors++; $display("FAIL full_instr got %h want 00020020", o_instr_w); end
    checks++; if (o_beats !== 32) begin errors++; $display("FAIL full_beats got %0d want 32", o_beats); end
    checks++; if (o_vcyc !== 32) begin errors++; $display("FAIL full_valid_cycles got %0d want 32", o_vcyc); end
    checks++; if (o_vmis !== 0) begin errors++; $display("FAIL full_valid_pair got %0d want 0", o_vmis); end
    checks++; if (cap_bad() !== 0) begin errors++; $display("FAIL full_beat_data got %0d bad want 0", cap_bad()); end
    checks++; if (o_res !== 32) begin errors++; $display("FAIL full_results got %0d want 32", o_res); end
    csr_rd(CSR_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL full_status got %h want 2", d); end
    csr_rd(CSR_RES_COUNT, d);
    checks++; if (d !== 32'd32) begin errors++; $display("FAIL full_res_count got %0d want 32", d); end
    for (int i = 0; i < 3; i++) begin
      read_res(addrs[i], v);
      checks++; if (v !== pat(8'h33, addrs[i])) begin errors++; $display("FAIL full_rd[%0d] got %h want %h", addrs[i], v[31:0], pat(8'h33, addrs[i]) & 32'hFFFF_FFFF); end
    end
  endtask

  task automatic test_rect();
    logic [31:0] d;
    logic [VW-1:0] v;
    csr_wr(CSR_CFG, 32'h0000_4008);  // rows 4, cols 8
    run_tile(8, 1'b0, 1'b0, 1'b0);
    checks++; if (o_instr_w !== 32'h0000_4008) begin errors++; $display("FAIL rect_instr got %h want 00004008", o_instr_w); end
    checks++; if (o_beats !== 4) begin errors++; $display("FAIL rect_beats got %0d want 4", o_beats); end
    checks++; if (cap_bad() !== 0) begin errors++; $display("FAIL rect_beat_data got %0d bad want 0", cap_bad()); end
    checks++; if (o_res !== 8) begin errors++; $display("FAIL rect_results got %0d want 8", o_res); end
    csr_rd(CSR_RES_COUNT, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL rect_res_count got %0d want 8", d); end
    csr_wr(CSR_CFG, 32'h0000_8003);  // rows 8, cols 3
    run_tile(3, 1'b0, 1'b0, 1'b0);
    checks++; if (o_beats !== 3) begin errors++; $display("FAIL tall_beats got %0d want 3", o_beats); end
    checks++; if (o_res !== 3) begin errors++; $display("FAIL tall_results got %0d want 3", o_res); end
    csr_rd(CSR_RES_COUNT, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL tall_res_count got %0d want 3", d); end
    read_res(5, v);  // written by the 8-result run, must persist
    checks++; if (v !== pat(8'h33, 5)) begin errors++; $display("FAIL res_persist got %h want %h", v[31:0], pat(8'h33, 5) & 32'hFFFF_FFFF); end
  endtask

  task automatic test_backpressure();
    csr_wr(CSR_CFG, 32'h0001_0010);
    run_tile(16, 1'b1, 1'b0, 1'b0);
    checks++; if (o_beats !== 16) begin errors++; $display("FAIL bp_beats got %0d want 16", o_beats); end
    checks++; if (o_vcyc < 16) begin errors++; $display("FAIL bp_valid_cycles got %0d want >=16", o_vcyc); end
    checks++; if (o_vmis !== 0) begin errors++; $display("FAIL bp_valid_pair got %0d want 0", o_vmis); end
    checks++; if (cap_bad() !== 0) begin errors++; $display("FAIL bp_beat_data got %0d bad want 0", cap_bad()); end
    checks++; if (o_res !== 16) begin errors++; $display("FAIL bp_results got %0d want 16", o_res); end
  endtask

  task automatic test_busy_ignores();
    logic [31:0] d;
    csr_wr(CSR_CFG, 32'h0000_6005);
    run_tile(5, 1'b0, 1'b1, 1'b0);
    checks++; if (o_beats !== 5) begin errors++; $display("FAIL busy_beats got %0d want 5", o_beats); end
    checks++; if (o_instr_n !== 1) begin errors++; $display("FAIL busy_instr_count got %0d want 1", o_instr_n); end
    checks++; if (o_res !== 5) begin errors++; $display("FAIL busy_results got %0d want 5", o_res); end
    csr_rd(CSR_CFG, d);
    checks++; if (d !== 32'h6005) begin errors++; $display("FAIL busy_cfg got %h want 6005", d); end
    csr_wr(CSR_CFG, 32'h0000_1001);
    run_tile(1, 1'b0, 1'b0, 1'b0);
    checks++; if (cap_rows.size() !== 1 || cap_rows[0] !== mrow[0]) begin
      errors++; $display("FAIL busy_ld_ignored got %h want %h", cap_rows[0][31:0], mrow[0][31:0]); end
  endtask

  task automatic test_load_start();
    csr_wr(CSR_CFG, 32'h0000_2002);
    run_tile(2, 1'b0, 1'b0, 1'b1);
    checks++; if (o_beats !== 2) begin errors++; $display("FAIL ldst_beats got %0d want 2", o_beats); end
    checks++; if (cap_rows.size() < 1 || cap_rows[0] !== pat(8'h44, 0)) begin
      errors++; $display("FAIL ldst_row0 got %h want %h", cap_rows[0][31:0], pat(8'h44, 0) & 32'hFFFF_FFFF); end
    checks++; if (cap_bad() !== 0) begin errors++; $display("FAIL ldst_beat_data got %0d bad want 0", cap_bad()); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    int cnt = 0;
    csr_wr(CSR_CFG, 32'h0002_0020);
    csr_wr(CSR_CTRL, 32'h1);
    for (int c = 0; c < 100; c++) begin
      bus.st_instr_ready = 1'b1; bus.st_rows_ready = 1'b1; bus.st_cols_ready = 1'b1;
      #1;
      if (bus.st_rows_valid) cnt++;
      if (cnt == 10) break;
      @(negedge clk);
    end
    checks++; if (cnt !== 10) begin errors++; $display("FAIL mid_reach_beat10 got %0d want 10", cnt); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid, bus.res_ready} !== 4'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %b want 0000", {bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid, bus.res_ready}); end
    csr_rd(CSR_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_status got %h want 0", d); end
    csr_rd(CSR_CFG, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_cfg got %h want 0", d); end
    @(negedge clk); rst = 1'b0;
    csr_wr(CSR_CFG, 32'h0000_3003);
    run_tile(3, 1'b0, 1'b0, 1'b0);
    checks++; if (o_instr_n !== 1 || o_beats !== 3) begin errors++; $display("FAIL mid_rerun_beats got %0d/%0d want 1/3", o_instr_n, o_beats); end
    checks++; if (cap_bad() !== 0) begin errors++; $display("FAIL mid_rerun_data got %0d bad want 0", cap_bad()); end
    csr_rd(CSR_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL mid_rerun_status got %h want 2", d); end
  endtask

  initial begin
    bus.csr_address = '0; bus.csr_write = 1'b0; bus.csr_writedata = '0; bus.csr_read = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.st_instr_ready = 1'b0; bus.st_rows_ready = 1'b0; bus.st_cols_ready = 1'b0;
    bus.res_data = '0; bus.res_valid = 1'b0; bus.rd_addr = '0;
    test_reset();
    test_cfg_err();
    test_full_tile();
    test_rect();
    test_backpressure();
    test_busy_ignores();
    test_load_start();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_tile_driver.md
SYSTOLIC_TILE_DRIVER -- requirements
Module: systolic_tile_driver

Interface
REQ-001 SHALL have parameter MAX_DIM, default 32, giving the maximum vectors per tile and the buffer depth.
REQ-002 SHALL have parameter VEC_W, default 256, giving the vector width (32 x 8-bit lanes, big endian).
REQ-003 SHALL have clock_sink  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have reset_sink_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have csr_address  in  8, csr_write  in  1, csr_writedata  in  32, csr_read  in  1, csr_readdata  out  32  control/status port.
REQ-006 SHALL have ld_valid  in  1, ld_sel  in  1 (0=row buffer, 1=col buffer), ld_addr  in  5, ld_data  in  VEC_W  operand load port.
REQ-007 SHALL have st_instr_data  out  32, st_instr_valid  out  1, st_instr_ready  in  1  instruction stream to the array.
REQ-008 SHALL have st_rows_data/st_cols_data  out  VEC_W, st_rows_valid/st_cols_valid  out  1, st_rows_ready/st_cols_ready  in  1  operand streams.
REQ-009 SHALL have res_data  in  VEC_W, res_valid  in  1, res_ready  out  1  result stream from the array.
REQ-010 SHALL have rd_addr  in  5, rd_data  out  VEC_W  result buffer read port, 1-cycle registered latency.

Function
REQ-011 CSR map: 0x00 CTRL (write bit0=1 -> start), 0x01 CFG (bits[11:0] n_cols, [23:12] n_rows), 0x02 STATUS (bit0 busy, bit1 done, bit2 cfg_err), 0x03 RES_COUNT; unmapped reads return 0; csr_readdata combinational from registers.
REQ-012 States: IDLE, INSTR, STREAM, COLLECT, DONE.
REQ-013 IDLE/DONE + start: if 1<=n_rows<=MAX_DIM and 1<=n_cols<=MAX_DIM -> INSTR, clear done/cfg_err/RES_COUNT; else set cfg_err, stay, no instruction issued.
REQ-014 Start while busy (INSTR/STREAM/COLLECT) SHALL be ignored; CFG writes while busy SHALL be ignored.
REQ-015 INSTR: st_instr_valid=1, st_instr_data={8'b0, n_rows, n_cols}; held stable until st_instr_valid&&st_instr_ready, then -> STREAM next cycle.
REQ-016 STREAM: beat count K=min(n_rows,n_cols); beat k drives row_buf[k] and col_buf[k] with both valids high together.
REQ-017 A beat SHALL advance only when st_rows_valid&&st_rows_ready&&st_cols_valid&&st_cols_ready; data and valids held otherwise (no partial advance).
REQ-018 After beat K-1 transfers, both valids SHALL drop next cycle and FSM -> COLLECT.
REQ-019 COLLECT: res_ready=1; each res_valid&&res_ready beat written to res_buf[RES_COUNT], RES_COUNT+1; after n_cols beats -> DONE, res_ready=0 same edge.
REQ-020 res_valid outside COLLECT SHALL be ignored (res_ready=0).
REQ-021 DONE: done=1, busy=0; result buffer contents persist until next collection overwrites.
REQ-022 ld_valid SHALL write the selected buffer only in IDLE or DONE; ignored when busy; ld_addr>=MAX_DIM ignored.
REQ-023 Load and start in the same cycle: load completes, start takes effect; STREAM reads post-load contents.
REQ-024 busy SHALL equal state in {INSTR, STREAM, COLLECT}.

Reset
REQ-025 On reset: state IDLE; all valids, res_ready, busy, done, cfg_err 0; RES_COUNT, CFG 0; csr_readdata 0; rd_data 0.
REQ-026 Reset mid-operation SHALL abort immediately with no further handshakes; buffer contents need not be cleared.

Structure
REQ-027 Shared package systolic_pkg SHALL hold the state enum, CSR addresses, MAX_DIM, VEC_W and instruction field positions, shared with the array top.
REQ-028 One sub-module vector_buffer (MAX_DIM x VEC_W, 1 write, 1 registered read) SHALL be instantiated three times (rows, cols, results).

Verification
REQ-029 CFG rows=32 cols=32, start, instant readies -> instr 0x020020 one beat, 32 operand beats in 32 cycles, 32 results captured, STATUS=0x2.
REQ-030 CFG rows=4 cols=8 -> exactly 4 operand beats, COLLECT accepts 8 results, RES_COUNT=8.
REQ-031 st_cols_ready toggled randomly during STREAM -> no beat lost or duplicated; rows/cols data equal buffer[k] in order.
REQ-032 CFG rows=0 or cols=33, start -> STATUS=0x4, st_instr_valid never asserted.
REQ-033 Reset asserted at beat 10 of STREAM -> valids 0 asynchronously, state IDLE, subsequent start runs clean.
REQ-034 ld_valid during COLLECT -> buffers unchanged; start during STREAM -> ignored, beat count unchanged.
